// File: rtl/pid_flght_cntrl_if.sv
// Signal bundle between the inertial front end, the PID core and the ESC side.
// The core uses the slave modport; whoever supplies attitudes and thrust uses master.
interface pid_flght_cntrl_if #(
    parameter int SPD_W = 11
);
    logic                vld;
    logic                inertial_cal;
    logic signed [15:0]  d_ptch;
    logic signed [15:0]  d_roll;
    logic signed [15:0]  d_yaw;
    logic signed [15:0]  ptch;
    logic signed [15:0]  roll;
    logic signed [15:0]  yaw;
    logic [8:0]          thrst;
    logic [SPD_W-1:0]    frnt_spd;
    logic [SPD_W-1:0]    bck_spd;
    logic [SPD_W-1:0]    lft_spd;
    logic [SPD_W-1:0]    rght_spd;
    logic                spd_vld;

    modport master (
        output vld, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
        input  frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld
    );

    modport slave (
        input  vld, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
        output frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld
    );
endinterface

// File: rtl/pid_flght_cntrl.sv
// PID flight-control core: per-axis P/D(/I) terms mixed into four registered motor speeds.
// Define PID_I_TERM_EN to build the anti-windup integrator; otherwise it is a PD controller.
module pid_flght_cntrl #(
    parameter int D_QUEUE_DEPTH = 14,
    parameter int ERR_W         = 10,
    parameter int DDIFF_W       = 6,
    parameter int D_COEFF       = 7,
    parameter int I_ACC_W       = 16,
    parameter int I_SHIFT       = 6,
    parameter int SPD_W         = 11,
    parameter int MIN_RUN_SPEED = 'h200,
    parameter int CAL_SPEED     = 'h1B0
) (
    input  logic               clk,
    input  logic               rst,
    pid_flght_cntrl_if.slave   bus
);

    localparam int ERR_MAX = 2 ** (ERR_W - 1) - 1;
    localparam int ERR_MIN = -(2 ** (ERR_W - 1));
    localparam int DD_MAX  = 2 ** (DDIFF_W - 1) - 1;
    localparam int DD_MIN  = -(2 ** (DDIFF_W - 1));
    localparam int SPD_MAX = 2 ** SPD_W - 1;
    // iterm keeps its post-shift width in both builds so the summation is shared.
    localparam int ITERM_W = I_ACC_W - I_SHIFT;

    function automatic int sat(input int v, input int lo, input int hi);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic [SPD_W-1:0] clamp_spd(input int v);
        if (v < 0) begin
            return '0;
        end else if (v > SPD_MAX) begin
            return SPD_W'(SPD_MAX);
        end
        return SPD_W'(v);
    endfunction

    logic               s1;
    logic signed [15:0] act [3];
    logic signed [15:0] des [3];
    int                 tot [3];
    logic               motor_off;

    assign act[0] = bus.ptch;
    assign act[1] = bus.roll;
    assign act[2] = bus.yaw;
    assign des[0] = bus.d_ptch;
    assign des[1] = bus.d_roll;
    assign des[2] = bus.d_yaw;

    assign motor_off = (bus.thrst == '0);

    // s1 marks the cycle in which err_q holds a freshly captured sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
        end else begin
            s1 <= bus.vld;
        end
    end

    for (genvar a = 0; a < 3; a++) begin : g_axis
        logic signed [16:0]       err_raw;
        logic signed [ERR_W-1:0]  err_q;
        logic signed [ERR_W-1:0]  queue [D_QUEUE_DEPTH];
        logic signed [ITERM_W-1:0] iterm;
        int                       e;
        int                       pterm;
        int                       ddiff;
        int                       dterm;

        assign err_raw = 17'(act[a]) - 17'(des[a]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                err_q <= '0;
            end else if (bus.vld) begin
                err_q <= ERR_W'(sat(int'(err_raw), ERR_MIN, ERR_MAX));
            end
        end

        // The oldest entry is the sample D_QUEUE_DEPTH readings back; it is read before the shift.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < D_QUEUE_DEPTH; i++) begin
                    queue[i] <= '0;
                end
            end else if (s1) begin
                queue[0] <= err_q;
                for (int i = 1; i < D_QUEUE_DEPTH; i++) begin
                    queue[i] <= queue[i-1];
                end
            end
        end

        always_comb begin
            e     = int'(err_q);
            pterm = (e >>> 1) + (e >>> 3);
            ddiff = sat(e - int'(queue[D_QUEUE_DEPTH-1]), DD_MIN, DD_MAX);
            dterm = D_COEFF * ddiff;
        end

`ifdef PID_I_TERM_EN
        localparam int ACC_MAX = 2 ** (I_ACC_W - 1) - 1;
        localparam int ACC_MIN = -(2 ** (I_ACC_W - 1));

        logic signed [I_ACC_W-1:0] acc;
        logic signed [I_ACC_W-1:0] acc_next;

        // The output mix uses the accumulator including the current sample.
        assign acc_next = I_ACC_W'(sat(int'(acc) + e, ACC_MIN, ACC_MAX));
        assign iterm    = acc_next[I_ACC_W-1:I_SHIFT];

        // Calibration or motor-off clears the windup even when a sample is arriving.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc <= '0;
            end else if (bus.inertial_cal || motor_off) begin
                acc <= '0;
            end else if (s1) begin
                acc <= acc_next;
            end
        end
`else
        assign iterm = '0;
`endif

        assign tot[a] = pterm + dterm + int'(iterm);
    end

    int               base;
    int               mix [4];
    logic [SPD_W-1:0] spd_next [4];

    always_comb begin
        base   = int'(bus.thrst) + MIN_RUN_SPEED;
        mix[0] = base - tot[0] - tot[2];
        mix[1] = base + tot[0] - tot[2];
        mix[2] = base - tot[1] + tot[2];
        mix[3] = base + tot[1] + tot[2];
        for (int m = 0; m < 4; m++) begin
            spd_next[m] = clamp_spd(mix[m]);
        end
    end

    // Calibration beats motor-off beats a fresh result; otherwise the speeds hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.frnt_spd <= '0;
            bus.bck_spd  <= '0;
            bus.lft_spd  <= '0;
            bus.rght_spd <= '0;
            bus.spd_vld  <= 1'b0;
        end else begin
            bus.spd_vld <= 1'b0;
            if (bus.inertial_cal) begin
                bus.frnt_spd <= SPD_W'(CAL_SPEED);
                bus.bck_spd  <= SPD_W'(CAL_SPEED);
                bus.lft_spd  <= SPD_W'(CAL_SPEED);
                bus.rght_spd <= SPD_W'(CAL_SPEED);
            end else if (motor_off) begin
                bus.frnt_spd <= '0;
                bus.bck_spd  <= '0;
                bus.lft_spd  <= '0;
                bus.rght_spd <= '0;
            end else if (s1) begin
                bus.frnt_spd <= spd_next[0];
                bus.bck_spd  <= spd_next[1];
                bus.lft_spd  <= spd_next[2];
                bus.rght_spd <= spd_next[3];
                bus.spd_vld  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pid_flght_cntrl.sv
// Self-checking bench for pid_flght_cntrl: directed scenarios plus randomized traffic
// compared each cycle against a sample-history reference model.
module tb_pid_flght_cntrl;

    localparam int D_DEPTH  = 14;
    localparam int ERR_W    = 10;
    localparam int DDIFF_W  = 6;
    localparam int D_COEFF  = 7;
    localparam int I_ACC_W  = 16;
    localparam int I_SHIFT  = 6;
    localparam int SPD_W    = 11;
    localparam int MIN_RUN  = 'h200;
    localparam int CAL_SPD  = 'h1B0;

`ifdef PID_I_TERM_EN
    localparam int EXP_STEP_FRNT = 510;
    localparam int EXP_STEP_BCK  = 1026;
    localparam int EXP_SAT_BCK   = 1055;
    localparam int EXP_Q14_FRNT  = 497;
    localparam int EXP_Q15_FRNT  = 713;
`else
    localparam int EXP_STEP_FRNT = 511;
    localparam int EXP_STEP_BCK  = 1025;
    localparam int EXP_SAT_BCK   = 1048;
    localparam int EXP_Q14_FRNT  = 511;
    localparam int EXP_Q15_FRNT  = 728;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    pid_flght_cntrl_if #(.SPD_W(SPD_W)) bus ();

    pid_flght_cntrl #(
        .D_QUEUE_DEPTH (D_DEPTH),
        .ERR_W         (ERR_W),
        .DDIFF_W       (DDIFF_W),
        .D_COEFF       (D_COEFF),
        .I_ACC_W       (I_ACC_W),
        .I_SHIFT       (I_SHIFT),
        .SPD_W         (SPD_W),
        .MIN_RUN_SPEED (MIN_RUN),
        .CAL_SPEED     (CAL_SPD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: per-axis history of past samples (newest first),
    // the running integral since the last clear, and the sample awaiting its result.
    int               hist [3][$];
    int               isum [3];
    bit               pend;
    int               pend_err [3];
    logic [SPD_W-1:0] exp_spd [4];
    logic             exp_vld;

    function automatic int sat(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int clamp_spd(input int v);
        if (v < 0) return 0;
        if (v > (1 << SPD_W) - 1) return (1 << SPD_W) - 1;
        return v;
    endfunction

    function automatic int rnd_att();
        if ($urandom_range(0, 3) == 0) begin
            return int'($urandom_range(0, 65535)) - 32768;
        end
        return int'($urandom_range(0, 600)) - 300;
    endfunction

    task automatic modelReset();
        for (int a = 0; a < 3; a++) begin
            hist[a].delete();
            isum[a]     = 0;
            pend_err[a] = 0;
        end
        pend = 1'b0;
        for (int m = 0; m < 4; m++) exp_spd[m] = '0;
        exp_vld = 1'b0;
    endtask

    // Advances the model by one clock edge using the inputs that were present before it.
    task automatic modelEdge();
        int act [3];
        int des [3];
        int tot [3];
        int ival [3];
        int m [4];
        int e;
        int old_e;
        int dd;
        int base;
        bit s1;
        bit cal;
        bit off;

        act[0] = int'(bus.ptch);   des[0] = int'(bus.d_ptch);
        act[1] = int'(bus.roll);   des[1] = int'(bus.d_roll);
        act[2] = int'(bus.yaw);    des[2] = int'(bus.d_yaw);
        cal = bus.inertial_cal;
        off = (bus.thrst == 9'd0);
        s1  = pend;

        for (int a = 0; a < 3; a++) begin
            tot[a]  = 0;
            ival[a] = isum[a];
            if (s1) begin
                e       = pend_err[a];
                old_e   = (hist[a].size() >= D_DEPTH) ? hist[a][D_DEPTH-1] : 0;
                dd      = sat(e - old_e, DDIFF_W);
                ival[a] = sat(isum[a] + e, I_ACC_W);
                tot[a]  = (e >>> 1) + (e >>> 3) + D_COEFF * dd;
`ifdef PID_I_TERM_EN
                tot[a]  = tot[a] + (ival[a] >>> I_SHIFT);
`endif
                hist[a].push_front(e);
                if (hist[a].size() > D_DEPTH) void'(hist[a].pop_back());
            end
            if (cal || off) isum[a] = 0;
            else if (s1)    isum[a] = ival[a];
        end

        exp_vld = 1'b0;
        if (cal) begin
            for (int k = 0; k < 4; k++) exp_spd[k] = SPD_W'(CAL_SPD);
        end else if (off) begin
            for (int k = 0; k < 4; k++) exp_spd[k] = '0;
        end else if (s1) begin
            base = int'(bus.thrst) + MIN_RUN;
            m[0] = base - tot[0] - tot[2];
            m[1] = base + tot[0] - tot[2];
            m[2] = base - tot[1] + tot[2];
            m[3] = base + tot[1] + tot[2];
            for (int k = 0; k < 4; k++) exp_spd[k] = SPD_W'(clamp_spd(m[k]));
            exp_vld = 1'b1;
        end

        pend = bus.vld;
        if (bus.vld) begin
            for (int a = 0; a < 3; a++) pend_err[a] = sat(act[a] - des[a], ERR_W);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_vld"},  32'(bus.spd_vld),  32'(exp_vld));
        checkValue({tag, "_frnt"}, 32'(bus.frnt_spd), 32'(exp_spd[0]));
        checkValue({tag, "_bck"},  32'(bus.bck_spd),  32'(exp_spd[1]));
        checkValue({tag, "_lft"},  32'(bus.lft_spd),  32'(exp_spd[2]));
        checkValue({tag, "_rght"}, 32'(bus.rght_spd), 32'(exp_spd[3]));
    endtask

    task automatic applyStimulus(input bit v, input bit cal, input int thr,
                                 input int dp, input int dr, input int dy,
                                 input int p, input int r, input int y);
        bus.vld          = v;
        bus.inertial_cal = cal;
        bus.thrst        = 9'(thr);
        bus.d_ptch       = 16'(dp);
        bus.d_roll       = 16'(dr);
        bus.d_yaw        = 16'(dy);
        bus.ptch         = 16'(p);
        bus.roll         = 16'(r);
        bus.yaw          = 16'(y);
    endtask

    // One clock: sample #1 after the edge, step the model, compare.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (rst) modelReset();
        else     modelEdge();
        checkOutput(tag);
    endtask

    task automatic checkAll(input string tag, input int want, input bit want_vld);
        checkValue({tag, "_vld"},  32'(bus.spd_vld),  32'(want_vld));
        checkValue({tag, "_frnt"}, 32'(bus.frnt_spd), 32'(want));
        checkValue({tag, "_bck"},  32'(bus.bck_spd),  32'(want));
        checkValue({tag, "_lft"},  32'(bus.lft_spd),  32'(want));
        checkValue({tag, "_rght"}, 32'(bus.rght_spd), 32'(want));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit v;
        bit cal;
        int thr;

        $display("[TB] pid_flght_cntrl bench starting");
        modelReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("reset");
        tick("reset");
        checkAll("reset_state", 0, 1'b0);

        // Calibration overrides outputs one cycle after it rises, with or without vld.
        rst = 1'b0;
        applyStimulus(1, 1, 'h100, 0, 0, 0, 0, 0, 0);
        tick("cal");
        checkAll("cal_speed", 'h1B0, 1'b0);
        applyStimulus(0, 1, 'h100, 0, 0, 0, 0, 0, 0);
        tick("cal");
        applyStimulus(1, 1, 'h100, 0, 0, 0, 0, 0, 0);
        tick("cal");
        applyStimulus(0, 1, 'h100, 0, 0, 0, 0, 0, 0);
        tick("cal");
        checkAll("cal_hold", 'h1B0, 1'b0);
        applyStimulus(0, 0, 'h100, 0, 0, 0, 0, 0, 0);
        tick("cal_exit");

        // Zero error: a single vld gives base speed two cycles later.
        applyStimulus(1, 0, 'h100, 0, 0, 0, 0, 0, 0);
        tick("zero_vld");
        applyStimulus(0, 0, 'h100, 0, 0, 0, 0, 0, 0);
        tick("zero_s1");
        checkAll("zero_err", 'h300, 1'b1);
        tick("zero_idle");

        // Pitch step of 64 with an all-zero history.
        applyStimulus(1, 0, 'h100, 0, 0, 0, 64, 0, 0);
        tick("step_vld");
        applyStimulus(0, 0, 'h100, 0, 0, 0, 64, 0, 0);
        tick("step_s1");
        checkValue("step_frnt", 32'(bus.frnt_spd), 32'(EXP_STEP_FRNT));
        checkValue("step_bck",  32'(bus.bck_spd),  32'(EXP_STEP_BCK));
        checkValue("step_lft",  32'(bus.lft_spd),  32'h300);
        checkValue("step_rght", 32'(bus.rght_spd), 32'h300);

        // Motor-off cycle clears the integrator, then a saturated pitch error.
        applyStimulus(0, 0, 0, -32768, 0, 0, 32767, 0, 0);
        tick("sat_clear");
        checkAll("sat_clear", 0, 1'b0);
        applyStimulus(1, 0, 1, -32768, 0, 0, 32767, 0, 0);
        tick("sat_vld");
        applyStimulus(0, 0, 1, -32768, 0, 0, 32767, 0, 0);
        tick("sat_s1");
        checkValue("sat_frnt", 32'(bus.frnt_spd), 32'd0);
        checkValue("sat_bck",  32'(bus.bck_spd),  32'(EXP_SAT_BCK));
        checkValue("sat_vld",  32'(bus.spd_vld),  32'd1);

        // Reset while a sample is in flight: it must never produce spd_vld.
        applyStimulus(1, 0, 'h100, 0, 0, 0, 64, 0, 0);
        tick("midrst_vld");
        rst = 1'b1;
        #1;
        checkAll("midrst_async", 0, 1'b0);
        applyStimulus(0, 0, 'h100, 0, 0, 0, 64, 0, 0);
        tick("midrst_hold");
        rst = 1'b0;
        tick("midrst_after");
        checkValue("midrst_no_vld", 32'(bus.spd_vld), 32'd0);

        // Fifteen back-to-back samples: the derivative sees the first one on the fifteenth.
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(1, 0, 'h100, 0, 0, 0, 64, 0, 0);
            tick("queue");
        end
        checkValue("queue_r14_frnt", 32'(bus.frnt_spd), 32'(EXP_Q14_FRNT));
        applyStimulus(0, 0, 'h100, 0, 0, 0, 64, 0, 0);
        tick("queue");
        checkValue("queue_r15_frnt", 32'(bus.frnt_spd), 32'(EXP_Q15_FRNT));
        checkValue("queue_r15_vld",  32'(bus.spd_vld),  32'd1);

        // Motor-off mid-run while samples keep arriving.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 'h100, 0, 0, 0, 64, 0, 0);
            tick("moff_run");
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 64, 0, 0);
        tick("moff");
        checkAll("moff_zero", 0, 1'b0);
        applyStimulus(1, 0, 'h100, 0, 0, 0, 64, 0, 0);
        tick("moff_resume");
        applyStimulus(0, 0, 'h100, 0, 0, 0, 64, 0, 0);
        tick("moff_resume");
        tick("moff_idle");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            cal = ($urandom_range(0, 24) == 0);
            thr = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 511));
            rst = ($urandom_range(0, 149) == 0);
            applyStimulus(v, cal, thr, rnd_att(), rnd_att(), rnd_att(),
                          rnd_att(), rnd_att(), rnd_att());
            tick("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
